// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Initiator for a 4-bit 74181-style ALU. A wide request is latched, then
// walked through the ALU one nibble per cycle, LSB first, with the carry or
// borrow out of each nibble fed into the next. The assembled result is held
// on a valid/ready response channel until the consumer takes it.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic                 req_cin,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cin,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [4:0]           alu_f,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_result,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_err
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [3:0]       nib_a, nib_b;
    logic [4:0]       ctrl;

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

    // Returns {alu_s, alu_m}; illegal ops select the constant-zero logic function.
    function automatic logic [4:0] alu_ctrl(input logic [2:0] op);
        case (op)
            OP_ADD:   return {4'b1001, 1'b0};
            OP_SUB:   return {4'b0110, 1'b0};
            OP_AND:   return {4'b1011, 1'b1};
            OP_XOR:   return {4'b0110, 1'b1};
            OP_NAND:  return {4'b0100, 1'b1};
            OP_PASSB: return {4'b1010, 1'b1};
            default:  return {4'b0011, 1'b1};
        endcase
    endfunction

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic, nibble steering into the ALU and result assembly.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_s     = 4'b0000;
        alu_m     = 1'b0;
        alu_cin   = 1'b0;
        alu_a     = 4'b0000;
        alu_b     = 4'b0000;
        nib_a     = 4'b0000;
        nib_b     = 4'b0000;
        ctrl      = alu_ctrl(op_q);

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    result_d = '0;
                    idx_d    = '0;
                    err_d    = is_illegal(req_op);
                    carry_d  = (req_op == OP_ADD) ? req_cin : (req_op == OP_SUB);
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        nib_a = a_q[4*n +: 4];
                        nib_b = b_q[4*n +: 4];
                        result_d[4*n +: 4] = alu_f[3:0];
                    end
                end
                alu_s   = ctrl[4:1];
                alu_m   = ctrl[0];
                alu_cin = carry_q;
                if (!is_illegal(op_q)) begin
                    alu_a = nib_a;
                    alu_b = nib_b;
                end
                // The ALU reports borrow for SUB; the chain carries its inverse.
                case (op_q)
                    OP_ADD:  carry_d = alu_f[4];
                    OP_SUB:  carry_d = ~alu_f[4];
                    default: carry_d = 1'b0;
                endcase
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = (result_q == '0);
    assign rsp_err    = err_q;

endmodule
